mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Memory-side responder for the pipeline's instruction and data ports. Serves iREN fetches and
//  dREN/dWEN requests from the EX/MEM latch, returning one-cycle ihit/dhit pulses.
//  Arbitrates both ports onto one single-ported RAM through the ramstate handshake.
//  Sits between the datapath (IF stage, EX/MEM latch) and the RAM model.
// PARAMETERS
//  ADDR_W   32  address width (word_t-aligned byte address)
//  DATA_W   32  data width
//  TIMEOUT  15  max cycles waiting for ramstate==ACCESS before aborting a transfer
// PORTS
//  CLK       in   1       clock, rising edge
//  nRST      in   1       reset, asynchronous, active-low
//  iREN      in   1       instruction read request (level, held until ihit)
//  iaddr     in   ADDR_W  instruction address
//  ihit      out  1       instruction transfer done, 1-cycle pulse
//  iload     out  DATA_W  fetched instruction, valid when ihit
//  dREN      in   1       data read request (level, held until dhit)
//  dWEN      in   1       data write request (level, held until dhit)
//  daddr     in   ADDR_W  data address
//  dstore    in   DATA_W  write data
//  dhit      out  1       data transfer done, 1-cycle pulse
//  dload     out  DATA_W  read data, valid when dhit
//  ramREN    out  1       RAM read strobe
//  ramWEN    out  1       RAM write strobe
//  ramaddr   out  ADDR_W  RAM address
//  ramstore  out  DATA_W  RAM write data
//  ramload   in   DATA_W  RAM read data
//  ramstate  in   2       ramstate_t: FREE/BUSY/ACCESS/ERROR
//  merr      out  1       transfer aborted (ERROR or timeout), 1-cycle pulse
// BEHAVIOUR
//  - Reset: state IDLE; last_d=0; timer=0; req regs=0; all outputs 0.
//  - FSM IDLE -> DGRANT | IGRANT -> IDLE. One grant per transfer; no overlap.
//  - IDLE grant rule, sampled each cycle:
//      (dREN|dWEN) & !(last_d & iREN) -> DGRANT; else iREN -> IGRANT; else stay.
//      Data has priority, but after a data grant a pending fetch wins the next grant (no starvation).
//  - On grant: capture addr, store data, write flag (dWEN wins if dREN&dWEN); last_d <= (grant==DGRANT).
//  - In a GRANT state: drive ramaddr/ramstore from captured regs.
//      ramWEN = captured write; ramREN = !captured write. All ram* are 0 in IDLE.
//  - Completion: ramstate==ACCESS in grant state -> the matching hit is 1 that same cycle (combinational).
//      dload/iload = ramload; next state IDLE.
//  - Hits are single-cycle: the EX/MEM latch drops dREN/dWEN on the edge after dhit.
//      The fetch port drops iREN the same way. Re-assertion in the following IDLE is a new request.
//  - Minimum latency: request in cycle N -> grant state N+1 -> hit N+1 if RAM answers ACCESS immediately.
//  - Timer: cleared on grant, +1 per grant cycle without ACCESS, saturating at TIMEOUT.
//      ramstate==ERROR or timer==TIMEOUT -> merr=1 for one cycle, no hit, back to IDLE.
//      The request is retried naturally while still asserted.
//  - Request withdrawn mid-grant (e.g. EX/MEM flush): transfer still completes and hit is still pulsed.
//      The requester ignores it. A write is never half-issued.
//  - Reset mid-transfer: immediate IDLE, RAM strobes drop asynchronously.
//  - ihit and dhit are never 1 in the same cycle; merr never coincides with a hit.
// STRUCTURE
//  - ramstate_t {FREE,BUSY,ACCESS,ERROR} and word_t come from cpu_types_pkg.
//  - Add arb_state_t {IDLE,DGRANT,IGRANT} to cpu_types_pkg.
//  - One natural sub-module: mem_timeout_ctr (clear, count enable, saturating, expired flag).
//  - Next-state/output logic in a single always_comb; registers in one always_ff.
// TESTING
//  1. Read: dREN=1, daddr=0x100; RAM BUSY 2 cycles then ACCESS, ramload=0xDEADBEEF
//     -> ramREN=1, ramaddr=0x100; dhit 1 cycle, dload=0xDEADBEEF.
//  2. Write: dWEN=1, daddr=0x200, dstore=0x12345678; ACCESS on first grant cycle
//     -> ramWEN=1 with those values; dhit in cycle N+1; ramREN=0.
//  3. Contention: iREN and dREN both high from reset -> data served first, then instruction.
//     With both held continuously -> grants alternate D,I,D,I.
//  4. Fault: RAM returns ERROR -> merr pulse, no dhit, grant reissued next cycle.
//     RAM stuck BUSY -> merr after exactly 15 grant cycles.
//  5. Flush: dREN dropped one cycle after grant -> dhit still pulses once; no second RAM access.
//  6. Async reset during DGRANT with ramWEN=1 -> ramWEN=0 and state IDLE before next CLK edge.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: data word, RAM handshake state and memory arbiter state.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } arb_state_t;

    // Width of a counter that must be able to hold the value `limit`.
    function automatic int ctr_width(input int limit);
        return (limit < 2) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Saturating wait counter for a RAM transfer; `expired` is high once the count
// has reached LIMIT.
module mem_timeout_ctr
    import cpu_types_pkg::*;
#(
    parameter int LIMIT = 15
) (
    input  logic CLK,
    input  logic nRST,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int W = ctr_width(LIMIT);
    localparam logic [W-1:0] LIMIT_V = W'(LIMIT);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // NOTE: default to holding the value first so no path leaves count_d unassigned (no latch).
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_en && (count_q != LIMIT_V)) begin
            count_d = count_q + W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == LIMIT_V);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the instruction fetch port and the EX/MEM data port onto one
// single-ported RAM, one transfer at a time, with abort on ERROR or timeout.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              ihit,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dhit,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              merr
);

    arb_state_t        state_q, state_d;
    logic              last_d_q, last_d_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] store_q, store_d;
    logic              wr_q, wr_d;

    logic              tmr_clear;
    logic              tmr_en;
    logic              tmr_expired;
    ramstate_t         rs;

    assign rs = ramstate_t'(ramstate);

    mem_timeout_ctr #(
        .LIMIT (TIMEOUT)
    ) u_timeout (
        .CLK      (CLK),
        .nRST     (nRST),
        .clear    (tmr_clear),
        .count_en (tmr_en),
        .expired  (tmr_expired)
    );

    always_comb begin
        state_d   = state_q;
        last_d_d  = last_d_q;
        addr_d    = addr_q;
        store_d   = store_q;
        wr_d      = wr_q;
        tmr_clear = 1'b0;
        tmr_en    = 1'b0;
        ihit      = 1'b0;
        iload     = '0;
        dhit      = 1'b0;
        dload     = '0;
        ramREN    = 1'b0;
        ramWEN    = 1'b0;
        ramaddr   = '0;
        ramstore  = '0;
        merr      = 1'b0;

        case (state_q)
            IDLE: begin
                // Data wins unless it had the last grant and a fetch is waiting.
                if ((dREN || dWEN) && !(last_d_q && iREN)) begin
                    state_d   = DGRANT;
                    addr_d    = daddr;
                    store_d   = dstore;
                    wr_d      = dWEN;
                    last_d_d  = 1'b1;
                    tmr_clear = 1'b1;
                end else if (iREN) begin
                    state_d   = IGRANT;
                    addr_d    = iaddr;
                    store_d   = '0;
                    wr_d      = 1'b0;
                    last_d_d  = 1'b0;
                    tmr_clear = 1'b1;
                end
            end

            DGRANT, IGRANT: begin
                // Driven from captured copies so a withdrawn request still completes cleanly.
                ramaddr  = addr_q;
                ramstore = store_q;
                ramWEN   = wr_q;
                ramREN   = !wr_q;
                if (rs == ACCESS) begin
                    state_d = IDLE;
                    if (state_q == DGRANT) begin
                        dhit  = 1'b1;
                        dload = ramload;
                    end else begin
                        ihit  = 1'b1;
                        iload = ramload;
                    end
                end else begin
                    tmr_en = 1'b1;
                    if ((rs == ERROR) || tmr_expired) begin
                        merr    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
            addr_q   <= '0;
            store_q  <= '0;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            addr_q   <= addr_d;
            store_q  <= store_d;
            wr_q     <= wr_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change on the falling edge, outputs
// are sampled 1 ns later, well away from the rising edge.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic        CLK;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        ihit;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dhit;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        merr;

    int total;
    int bad;

    mem_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (15)
    ) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .ihit     (ihit),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dhit     (dhit),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .merr     (merr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge CLK);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        nRST     = 1'b0;
        iREN     = 1'b0;
        iaddr    = '0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        daddr    = '0;
        dstore   = '0;
        ramload  = '0;
        ramstate = FREE;

        // Reset state
        #3;
        check("rst_ramREN", ramREN, 0);
        check("rst_ramWEN", ramWEN, 0);
        check("rst_ihit", ihit, 0);
        check("rst_dhit", dhit, 0);
        check("rst_merr", merr, 0);
        check("rst_ramaddr", ramaddr, 0);
        cyc();
        nRST = 1'b1;

        // 1. Read with two BUSY cycles
        cyc(); dREN = 1'b1; daddr = 32'h100; ramstate = BUSY; #1;
        check("rd_idle_ramREN", ramREN, 0);
        cyc(); #1;
        check("rd_g1_ramREN", ramREN, 1);
        check("rd_g1_ramaddr", ramaddr, 32'h100);
        check("rd_g1_dhit", dhit, 0);
        cyc(); #1;
        check("rd_g2_dhit", dhit, 0);
        cyc(); ramstate = ACCESS; ramload = 32'hDEADBEEF; #1;
        check("rd_dhit", dhit, 1);
        check("rd_dload", dload, 32'hDEADBEEF);
        check("rd_ihit", ihit, 0);
        check("rd_merr", merr, 0);
        cyc(); dREN = 1'b0; ramstate = FREE; #1;
        check("rd_after_dhit", dhit, 0);
        check("rd_after_ramREN", ramREN, 0);

        // 2. Write answered on the first grant cycle
        cyc(); dWEN = 1'b1; daddr = 32'h200; dstore = 32'h12345678; ramstate = ACCESS; #1;
        check("wr_idle_ramWEN", ramWEN, 0);
        check("wr_idle_dhit", dhit, 0);
        cyc(); #1;
        check("wr_ramWEN", ramWEN, 1);
        check("wr_ramREN", ramREN, 0);
        check("wr_ramaddr", ramaddr, 32'h200);
        check("wr_ramstore", ramstore, 32'h12345678);
        check("wr_dhit", dhit, 1);
        cyc(); dWEN = 1'b0; #1;
        check("wr_after_ramWEN", ramWEN, 0);
        check("wr_after_dhit", dhit, 0);

        // 3. Contention from reset, both held: D, I, D, I
        nRST = 1'b0; #1;
        cyc();
        iREN = 1'b1; iaddr = 32'h40; dREN = 1'b1; daddr = 32'h300;
        ramstate = ACCESS; ramload = 32'hA5A50001; nRST = 1'b1; #1;
        check("ct_idle_ramREN", ramREN, 0);
        cyc(); #1;
        check("ct_d1_dhit", dhit, 1);
        check("ct_d1_ihit", ihit, 0);
        check("ct_d1_ramaddr", ramaddr, 32'h300);
        check("ct_d1_dload", dload, 32'hA5A50001);
        cyc(); ramload = 32'hA5A50002; #1;
        check("ct_idle2_ramREN", ramREN, 0);
        cyc(); #1;
        check("ct_i1_ihit", ihit, 1);
        check("ct_i1_dhit", dhit, 0);
        check("ct_i1_ramaddr", ramaddr, 32'h40);
        check("ct_i1_iload", iload, 32'hA5A50002);
        cyc(); #1;
        check("ct_idle3_ramREN", ramREN, 0);
        cyc(); #1;
        check("ct_d2_dhit", dhit, 1);
        check("ct_d2_ihit", ihit, 0);
        cyc(); #1;
        check("ct_idle4_ramREN", ramREN, 0);
        cyc(); #1;
        check("ct_i2_ihit", ihit, 1);
        check("ct_i2_dhit", dhit, 0);
        cyc(); iREN = 1'b0; dREN = 1'b0; #1;
        check("ct_end_ramREN", ramREN, 0);

        // 4a. RAM ERROR, then retried grant succeeds
        cyc(); dREN = 1'b1; daddr = 32'h400; ramstate = ERROR; #1;
        check("er_idle_merr", merr, 0);
        check("er_idle_ramREN", ramREN, 0);
        cyc(); #1;
        check("er_merr", merr, 1);
        check("er_dhit", dhit, 0);
        check("er_ramREN", ramREN, 1);
        cyc(); #1;
        check("er_idle2_merr", merr, 0);
        check("er_idle2_ramREN", ramREN, 0);
        cyc(); ramstate = ACCESS; ramload = 32'hB0B0B0B0; #1;
        check("er_retry_ramaddr", ramaddr, 32'h400);
        check("er_retry_dhit", dhit, 1);
        check("er_retry_merr", merr, 0);
        cyc(); dREN = 1'b0; ramstate = BUSY; #1;
        check("er_end_ramREN", ramREN, 0);

        // 4b. RAM stuck BUSY: merr after 15 full grant cycles
        cyc(); dREN = 1'b1; daddr = 32'h500; #1;
        check("to_idle_ramREN", ramREN, 0);
        for (int i = 1; i <= 15; i++) begin
            cyc(); #1;
            check($sformatf("to_wait%0d_merr", i), merr, 0);
        end
        check("to_wait_ramREN", ramREN, 1);
        cyc(); #1;
        check("to_merr", merr, 1);
        check("to_dhit", dhit, 0);
        cyc(); dREN = 1'b0; #1;
        check("to_after_merr", merr, 0);
        check("to_after_ramREN", ramREN, 0);

        // 5. Request withdrawn one cycle after grant
        cyc(); dREN = 1'b1; daddr = 32'h600; ramstate = BUSY; #1;
        check("fl_idle_ramREN", ramREN, 0);
        cyc(); #1;
        check("fl_g1_ramREN", ramREN, 1);
        cyc(); dREN = 1'b0; #1;
        check("fl_g2_ramREN", ramREN, 1);
        check("fl_g2_ramaddr", ramaddr, 32'h600);
        cyc(); ramstate = ACCESS; ramload = 32'hC0C0C0C0; #1;
        check("fl_dhit", dhit, 1);
        check("fl_dload", dload, 32'hC0C0C0C0);
        cyc(); #1;
        check("fl_after_dhit", dhit, 0);
        check("fl_after_ramREN", ramREN, 0);
        cyc(); #1;
        check("fl_no_reaccess", ramREN, 0);

        // 6. Async reset during a write grant
        cyc(); dWEN = 1'b1; daddr = 32'h700; dstore = 32'h0BADF00D; ramstate = BUSY; #1;
        check("ar_idle_ramWEN", ramWEN, 0);
        cyc(); #1;
        check("ar_grant_ramWEN", ramWEN, 1);
        #1; nRST = 1'b0; #1;
        check("ar_ramWEN", ramWEN, 0);
        check("ar_ramREN", ramREN, 0);
        check("ar_ramaddr", ramaddr, 0);
        cyc(); dWEN = 1'b0; nRST = 1'b1; #1;
        check("ar_post_ramWEN", ramWEN, 0);
        cyc(); #1;
        check("ar_post2_ramWEN", ramWEN, 0);
        check("ar_post2_ramREN", ramREN, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
